// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store sequencer: turns RV32 byte/half/word accesses into word-wide
// data-memory requests with byte enables and load extension. Optional macro: MISALIGN_TRAP_EN.
module data_mem_access_unit #(
    parameter int ADDR_W = 30
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        MEM_READ,
    input  logic [2:0]        MEM_WRITE,
    input  logic [31:0]       ADDRESS,
    input  logic [31:0]       WRITE_DATA,
    output logic [31:0]       READ_DATA,
    output logic              BUSY_WAIT,
    output logic              MISALIGNED,
    output logic [ADDR_W-1:0] DM_ADDR,
    output logic [31:0]       DM_WRDATA,
    output logic [3:0]        DM_BYTE_EN,
    output logic              DM_READ,
    output logic              DM_WRITE,
    input  logic [31:0]       DM_RDDATA,
    input  logic              DM_ACK,
    output logic [1:0]        o_dbg_state
);

    // Memory handshake: DM_READ/DM_WRITE rise with address, data and enables already
    // stable, all of which are held until the single-cycle DM_ACK strobe is seen.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t            r_state;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [31:0]       r_dm_wrdata;
    logic [3:0]        r_dm_byte_en;
    logic              r_dm_read;
    logic              r_dm_write;
    logic [31:0]       r_read_data;
    logic              r_misaligned;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_lane;

    logic              w_ld_req;
    logic              w_st_req;
    logic [1:0]        w_size;
    logic [3:0]        w_byte_en;
    logic [31:0]       w_st_data;
    logic              w_misaligned;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_ld_result;

    // A load takes priority when both enables are raised in the same cycle.
    assign w_ld_req = MEM_READ[3];
    assign w_st_req = MEM_WRITE[2] & ~MEM_READ[3];

    always_comb begin
        w_size = SZ_W;
        if (w_ld_req) begin
            case (MEM_READ[1:0])
                2'b00:   w_size = SZ_B;
                2'b01:   w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end else begin
            case (MEM_WRITE[1:0])
                2'b00:   w_size = SZ_B;
                2'b01:   w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end
    end

    always_comb begin
        w_byte_en = 4'b1111;
        w_st_data = WRITE_DATA;
        case (w_size)
            SZ_B: begin
                w_byte_en = 4'b0001 << ADDRESS[1:0];
                w_st_data = {4{WRITE_DATA[7:0]}};
            end
            SZ_H: begin
                w_byte_en = ADDRESS[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{WRITE_DATA[15:0]}};
            end
            default: begin
                w_byte_en = 4'b1111;
                w_st_data = WRITE_DATA;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misaligned = ((w_size == SZ_H) && ADDRESS[0]) ||
                          ((w_size == SZ_W) && (ADDRESS[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Lane select and extension use the address/funct3 captured when the load was issued.
    always_comb begin
        w_ld_byte   = 8'h00;
        w_ld_half   = r_ld_lane[1] ? DM_RDDATA[31:16] : DM_RDDATA[15:0];
        w_ld_result = DM_RDDATA;
        case (r_ld_lane)
            2'd0:    w_ld_byte = DM_RDDATA[7:0];
            2'd1:    w_ld_byte = DM_RDDATA[15:8];
            2'd2:    w_ld_byte = DM_RDDATA[23:16];
            default: w_ld_byte = DM_RDDATA[31:24];
        endcase
        case (r_ld_funct3[1:0])
            2'b00:   w_ld_result = r_ld_funct3[2] ? {24'h0, w_ld_byte}
                                                  : {{24{w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_result = r_ld_funct3[2] ? {16'h0, w_ld_half}
                                                  : {{16{w_ld_half[15]}}, w_ld_half};
            default: w_ld_result = DM_RDDATA;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_dm_addr    <= '0;
            r_dm_wrdata  <= '0;
            r_dm_byte_en <= '0;
            r_dm_read    <= 1'b0;
            r_dm_write   <= 1'b0;
            r_read_data  <= '0;
            r_misaligned <= 1'b0;
            r_ld_funct3  <= '0;
            r_ld_lane    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((w_ld_req || w_st_req) && w_misaligned) begin
                        r_misaligned <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (w_ld_req) begin
                        r_dm_addr    <= ADDRESS[ADDR_W+1:2];
                        r_dm_byte_en <= w_byte_en;
                        r_dm_read    <= 1'b1;
                        r_ld_funct3  <= MEM_READ[2:0];
                        r_ld_lane    <= ADDRESS[1:0];
                        r_state      <= S_RD_WAIT;
                    end else if (w_st_req) begin
                        r_dm_addr    <= ADDRESS[ADDR_W+1:2];
                        r_dm_byte_en <= w_byte_en;
                        r_dm_wrdata  <= w_st_data;
                        r_dm_write   <= 1'b1;
                        r_state      <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (DM_ACK) begin
                        r_dm_read   <= 1'b0;
                        r_read_data <= w_ld_result;
                        r_state     <= S_DONE;
                    end
                end
                S_WR_WAIT: begin
                    if (DM_ACK) begin
                        r_dm_write <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                default: begin
                    r_misaligned <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY_WAIT   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT) ||
                         ((r_state == S_IDLE) && (MEM_READ[3] || MEM_WRITE[2]));
    assign READ_DATA   = r_read_data;
    assign MISALIGNED  = r_misaligned;
    assign DM_ADDR     = r_dm_addr;
    assign DM_WRDATA   = r_dm_wrdata;
    assign DM_BYTE_EN  = r_dm_byte_en;
    assign DM_READ     = r_dm_read;
    assign DM_WRITE    = r_dm_write;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit: vector table of accesses plus hand-written
// reset/ACK corner sequences. Honours MISALIGN_TRAP_EN for the misaligned vectors.
module tb_data_mem_access_unit;

    logic        CLK;
    logic        RESET;
    logic [3:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSY_WAIT;
    logic        MISALIGNED;
    logic [29:0] DM_ADDR;
    logic [31:0] DM_WRDATA;
    logic [3:0]  DM_BYTE_EN;
    logic        DM_READ;
    logic        DM_WRITE;
    logic [31:0] DM_RDDATA;
    logic        DM_ACK;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_access_unit #(.ADDR_W(30)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
        .BUSY_WAIT(BUSY_WAIT), .MISALIGNED(MISALIGNED), .DM_ADDR(DM_ADDR),
        .DM_WRDATA(DM_WRDATA), .DM_BYTE_EN(DM_BYTE_EN), .DM_READ(DM_READ),
        .DM_WRITE(DM_WRITE), .DM_RDDATA(DM_RDDATA), .DM_ACK(DM_ACK),
        .o_dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  mem_read;
        logic [2:0]  mem_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rddata;
        int          ack_at;
        logic        is_store;
        logic [29:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wr;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic [3:0] mr, logic [2:0] mw, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, int ack,
                                logic st, logic [29:0] ea, logic [3:0] eb,
                                logic [31:0] ew, logic [31:0] er, logic em);
        vec_t v;
        v.mem_read = mr; v.mem_write = mw; v.addr = a; v.wdata = wd;
        v.rddata = rd; v.ack_at = ack; v.is_store = st; v.exp_addr = ea;
        v.exp_be = eb; v.exp_wr = ew; v.exp_rd = er; v.exp_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_READ = 4'h0; MEM_WRITE = 3'h0; ADDRESS = '0; WRITE_DATA = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int busy_n;
        bit done;
        int exp_busy;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_busy = v.exp_mis ? 1 : v.ack_at + 1;
        MEM_READ = v.mem_read; MEM_WRITE = v.mem_write;
        ADDRESS = v.addr; WRITE_DATA = v.wdata;
        cyc = 0; busy_n = 0; done = 0;
        while (!done && cyc < 50) begin
            @(negedge CLK);
            if (BUSY_WAIT) begin
                busy_n++;
                if (cyc >= 1 && !v.exp_mis) begin
                    chk({tag, " dm_addr"}, {2'b00, DM_ADDR}, {2'b00, v.exp_addr});
                    chk({tag, " byte_en"}, {28'h0, DM_BYTE_EN}, {28'h0, v.exp_be});
                    chk({tag, " dm_read"}, {31'h0, DM_READ}, {31'h0, ~v.is_store});
                    chk({tag, " dm_write"}, {31'h0, DM_WRITE}, {31'h0, v.is_store});
                    if (v.is_store) chk({tag, " wrdata"}, DM_WRDATA, v.exp_wr);
                end
                DM_ACK = (cyc == v.ack_at) && !v.exp_mis;
                DM_RDDATA = v.rddata;
            end else begin
                done = 1;
                chk({tag, " busy_cycles"}, busy_n, exp_busy);
                chk({tag, " done_state"}, {30'h0, dbg_state}, 32'd3);
                chk({tag, " read_data"}, READ_DATA, v.exp_rd);
                chk({tag, " misaligned"}, {31'h0, MISALIGNED}, {31'h0, v.exp_mis});
                chk({tag, " req_dropped"}, {30'h0, DM_READ, DM_WRITE}, 32'd0);
                idle_inputs();
            end
            cyc++;
            @(posedge CLK); #1;
            DM_ACK = 1'b0;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: BUSY_WAIT never dropped, required drop within 50 cycles", tag);
            idle_inputs();
        end
        chk({tag, " back_idle"}, {30'h0, dbg_state}, 32'd0);
        chk({tag, " mis_clear"}, {31'h0, MISALIGNED}, 32'd0);
    endtask

    initial begin
        RESET = 1'b1; DM_ACK = 1'b0; DM_RDDATA = '0;
        idle_inputs();

        vecs[0]  = mk(4'b0000, 3'b110, 32'h100, 32'hDEADBEEF, 32'h0, 3, 1, 30'h40, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        vecs[1]  = mk(4'b1000, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 30'h40, 4'b1000, 32'h0, 32'hFFFFFF80, 0);
        vecs[2]  = mk(4'b1100, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 30'h40, 4'b1000, 32'h0, 32'h00000080, 0);
        vecs[3]  = mk(4'b0000, 3'b101, 32'h206, 32'h0000ABCD, 32'h0, 2, 1, 30'h81, 4'b1100, 32'hABCDABCD, 32'h00000080, 0);
        vecs[4]  = mk(4'b1001, 3'b000, 32'h202, 32'h0, 32'h80017FFF, 1, 0, 30'h80, 4'b1100, 32'h0, 32'hFFFF8001, 0);
        vecs[5]  = mk(4'b1101, 3'b000, 32'h200, 32'h0, 32'h8001F00D, 1, 0, 30'h80, 4'b0011, 32'h0, 32'h0000F00D, 0);
        vecs[6]  = mk(4'b1010, 3'b000, 32'h010, 32'h0, 32'h12345678, 2, 0, 30'h04, 4'b1111, 32'h0, 32'h12345678, 0);
        vecs[7]  = mk(4'b0000, 3'b100, 32'h301, 32'h000000A5, 32'h0, 1, 1, 30'hC0, 4'b0010, 32'hA5A5A5A5, 32'h12345678, 0);
        vecs[8]  = mk(4'b1000, 3'b000, 32'h001, 32'h0, 32'h00007F00, 1, 0, 30'h00, 4'b0010, 32'h0, 32'h0000007F, 0);
        vecs[9]  = mk(4'b1010, 3'b110, 32'h044, 32'h77777777, 32'hCAFEF00D, 1, 0, 30'h11, 4'b1111, 32'h0, 32'hCAFEF00D, 0);
        vecs[10] = mk(4'b1011, 3'b000, 32'h008, 32'h0, 32'h11223344, 2, 0, 30'h02, 4'b1111, 32'h0, 32'h11223344, 0);
`ifdef MISALIGN_TRAP_EN
        vecs[11] = mk(4'b1010, 3'b000, 32'h102, 32'h0, 32'h55667788, 1, 0, 30'h40, 4'b1111, 32'h0, 32'h11223344, 1);
        vecs[12] = mk(4'b1001, 3'b000, 32'h203, 32'h0, 32'hBEEF0000, 1, 0, 30'h80, 4'b1100, 32'h0, 32'h11223344, 1);
`else
        vecs[11] = mk(4'b1010, 3'b000, 32'h102, 32'h0, 32'h55667788, 1, 0, 30'h40, 4'b1111, 32'h0, 32'h55667788, 0);
        vecs[12] = mk(4'b1001, 3'b000, 32'h203, 32'h0, 32'hBEEF0000, 1, 0, 30'h80, 4'b1100, 32'h0, 32'hFFFFBEEF, 0);
`endif

        // Reset held two cycles, then quiet idle.
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst state", {30'h0, dbg_state}, 32'd0);
        chk("rst busy", {31'h0, BUSY_WAIT}, 32'd0);
        chk("rst dm_ctl", {30'h0, DM_READ, DM_WRITE}, 32'd0);
        chk("rst dm_addr", {2'b00, DM_ADDR}, 32'd0);
        chk("rst wrdata", DM_WRDATA, 32'd0);
        chk("rst byte_en", {28'h0, DM_BYTE_EN}, 32'd0);
        chk("rst read_data", READ_DATA, 32'd0);
        chk("rst misaligned", {31'h0, MISALIGNED}, 32'd0);

        // Reset in the middle of a read wait, with a stray ACK afterwards.
        @(posedge CLK); #1;
        MEM_READ = 4'b1010; ADDRESS = 32'h20;
        @(posedge CLK); #1;
        chk("mid state rd_wait", {30'h0, dbg_state}, 32'd1);
        chk("mid dm_read", {31'h0, DM_READ}, 32'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        idle_inputs();
        chk("mid after rst state", {30'h0, dbg_state}, 32'd0);
        chk("mid after rst dm_read", {31'h0, DM_READ}, 32'd0);
        DM_RDDATA = 32'hFFFFFFFF; DM_ACK = 1'b1;
        @(posedge CLK); #1;
        DM_ACK = 1'b0;
        @(negedge CLK);
        chk("mid late ack state", {30'h0, dbg_state}, 32'd0);
        chk("mid late ack busy", {31'h0, BUSY_WAIT}, 32'd0);
        chk("mid late ack read_data", READ_DATA, 32'd0);
        @(posedge CLK); #1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // ACK strobed while idle must not disturb anything.
        DM_RDDATA = 32'h0BADF00D; DM_ACK = 1'b1;
        @(negedge CLK);
        chk("idle ack busy", {31'h0, BUSY_WAIT}, 32'd0);
        @(posedge CLK); #1;
        DM_ACK = 1'b0;
        @(negedge CLK);
        chk("idle ack state", {30'h0, dbg_state}, 32'd0);
        chk("idle ack read_data", READ_DATA, vecs[12].exp_rd);
        chk("idle ack dm_ctl", {30'h0, DM_READ, DM_WRITE}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
